// File: rtl/food_placer.sv
`default_nettype none
// food_placer: draws grid-aligned food positions from a free-running LFSR, filters them against
// a playfield window and (optionally) a snake-occupancy query, and commits the first acceptable one.
module food_placer #(
   parameter int unsigned       COORD_W    = 10,
   parameter int unsigned       LFSR_W     = 20,
   parameter logic [LFSR_W-1:0] LFSR_TAPS  = 20'h90000,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = 20'h00001,
   parameter int unsigned       GRID_SHIFT = 3,
   parameter int unsigned       X_LO       = 152,
   parameter int unsigned       X_HI       = 776,
   parameter int unsigned       Y_LO       = 40,
   parameter int unsigned       Y_HI       = 504,
   parameter int unsigned       OCC_CHECK  = 1,
   parameter int unsigned       MAX_TRIES  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               place_req,
   output logic               busy,
   output logic               place_done,
   output logic               place_fail,
   output logic               food_valid,
   output logic [COORD_W-1:0] x_food,
   output logic [COORD_W-1:0] y_food,
   output logic               occ_query_valid,
   output logic [COORD_W-1:0] occ_query_x,
   output logic [COORD_W-1:0] occ_query_y,
   input  logic               occ_resp_valid,
   input  logic               occ_hit
);

   localparam int unsigned        TRY_W     = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0]   TRY_LIMIT = TRY_W'(MAX_TRIES);
   localparam logic [COORD_W-1:0] GRID_MASK = ~((COORD_W'(1) << GRID_SHIFT) - COORD_W'(1));
   localparam logic [COORD_W:0]   X_BASE    = (COORD_W+1)'(X_LO);
   localparam logic [COORD_W:0]   Y_BASE    = (COORD_W+1)'(Y_LO);
   localparam logic [COORD_W:0]   X_SPAN    = (COORD_W+1)'(X_HI - X_LO + 1);
   localparam logic [COORD_W:0]   Y_SPAN    = (COORD_W+1)'(Y_HI - Y_LO + 1);
   localparam bit                 USE_OCC   = (OCC_CHECK != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAW  = 2'd1,
      S_QUERY = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
   logic [TRY_W-1:0]   tries_q, tries_d;
   logic               fail_q, fail_d;
   logic               food_valid_q, food_valid_d;
   logic [COORD_W-1:0] x_food_q, x_food_d;
   logic [COORD_W-1:0] y_food_q, y_food_d;
   logic               qv_q, qv_d;
   logic [COORD_W-1:0] qx_q, qx_d;
   logic [COORD_W-1:0] qy_q, qy_d;

   logic [COORD_W-1:0] cand_x, cand_y;
   logic [COORD_W:0]   off_x, off_y;
   logic               cand_ok;
   logic [TRY_W-1:0]   tries_inc;
   logic               tries_exhausted;

   assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

   assign cand_x = lfsr_q[COORD_W-1:0] & GRID_MASK;
   assign cand_y = lfsr_q[2*COORD_W-1:COORD_W] & GRID_MASK;

   // Single unsigned compare per axis: values below the low bound wrap to above any span.
   assign off_x   = {1'b0, cand_x} - X_BASE;
   assign off_y   = {1'b0, cand_y} - Y_BASE;
   assign cand_ok = (off_x < X_SPAN) && (off_y < Y_SPAN);

   assign tries_inc       = tries_q + TRY_W'(1);
   assign tries_exhausted = (tries_inc == TRY_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lfsr_q       <= LFSR_SEED;
         tries_q      <= '0;
         fail_q       <= 1'b0;
         food_valid_q <= 1'b0;
         x_food_q     <= '0;
         y_food_q     <= '0;
         qv_q         <= 1'b0;
         qx_q         <= '0;
         qy_q         <= '0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         tries_q      <= tries_d;
         fail_q       <= fail_d;
         food_valid_q <= food_valid_d;
         x_food_q     <= x_food_d;
         y_food_q     <= y_food_d;
         qv_q         <= qv_d;
         qx_q         <= qx_d;
         qy_q         <= qy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tries_d      = tries_q;
      fail_d       = fail_q;
      food_valid_d = food_valid_q;
      x_food_d     = x_food_q;
      y_food_d     = y_food_q;
      qv_d         = qv_q;
      qx_d         = qx_q;
      qy_d         = qy_q;

      case (state_q)
         S_IDLE: begin
            if (place_req) begin
               state_d = S_DRAW;
               tries_d = '0;
            end
         end

         S_DRAW: begin
            if (!cand_ok) begin
               tries_d = tries_inc;
               if (tries_exhausted) begin
                  state_d = S_DONE;
                  fail_d  = 1'b1;
               end
            end else if (!USE_OCC) begin
               x_food_d     = cand_x;
               y_food_d     = cand_y;
               food_valid_d = 1'b1;
               fail_d       = 1'b0;
               state_d      = S_DONE;
            end else begin
               qx_d    = cand_x;
               qy_d    = cand_y;
               qv_d    = 1'b1;
               state_d = S_QUERY;
            end
         end

         S_QUERY: begin
            // Query fields stay frozen until the answer is sampled.
            if (occ_resp_valid) begin
               qv_d = 1'b0;
               if (!occ_hit) begin
                  x_food_d     = qx_q;
                  y_food_d     = qy_q;
                  food_valid_d = 1'b1;
                  fail_d       = 1'b0;
                  state_d      = S_DONE;
               end else begin
                  tries_d = tries_inc;
                  if (tries_exhausted) begin
                     state_d = S_DONE;
                     fail_d  = 1'b1;
                  end else begin
                     state_d = S_DRAW;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy            = (state_q == S_DRAW) || (state_q == S_QUERY);
   assign place_done      = (state_q == S_DONE);
   assign place_fail      = (state_q == S_DONE) && fail_q;
   assign food_valid      = food_valid_q;
   assign x_food          = x_food_q;
   assign y_food          = y_food_q;
   assign occ_query_valid = qv_q;
   assign occ_query_x     = qx_q;
   assign occ_query_y     = qy_q;

endmodule
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// Directed self-checking bench for food_placer: four instances with different windows and
// occupancy modes share one clock/reset, so a single LFSR model predicts every candidate.
module tb_food_placer;

   logic       clk;
   logic       rst_n;
   logic       req   [4];
   logic       busy  [4];
   logic       done  [4];
   logic       fail  [4];
   logic       fv    [4];
   logic [9:0] xf    [4];
   logic [9:0] yf    [4];
   logic       qv    [4];
   logic [9:0] qx    [4];
   logic [9:0] qy    [4];
   logic       rv    [3];
   logic       hit   [3];
   logic       rv3;

   int n_cmp;
   int n_bad;

   logic [19:0] m_lfsr;
   logic [19:0] m_prev;

   // Instance 3 gets an always-miss responder answering in the same cycle as the query.
   assign rv3 = qv[3];

   food_placer #(.OCC_CHECK(0), .X_LO(0), .X_HI(1016), .Y_LO(0), .Y_HI(1016)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .place_req(req[0]), .busy(busy[0]), .place_done(done[0]),
      .place_fail(fail[0]), .food_valid(fv[0]), .x_food(xf[0]), .y_food(yf[0]),
      .occ_query_valid(qv[0]), .occ_query_x(qx[0]), .occ_query_y(qy[0]),
      .occ_resp_valid(rv[0]), .occ_hit(hit[0]));

   food_placer #(.OCC_CHECK(1), .X_LO(0), .X_HI(1016), .Y_LO(0), .Y_HI(1016)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .place_req(req[1]), .busy(busy[1]), .place_done(done[1]),
      .place_fail(fail[1]), .food_valid(fv[1]), .x_food(xf[1]), .y_food(yf[1]),
      .occ_query_valid(qv[1]), .occ_query_x(qx[1]), .occ_query_y(qy[1]),
      .occ_resp_valid(rv[1]), .occ_hit(hit[1]));

   // 1001 is not a multiple of 8, so no aligned candidate can ever land in this window.
   food_placer #(.OCC_CHECK(0), .X_LO(1001), .X_HI(1001), .MAX_TRIES(5)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .place_req(req[2]), .busy(busy[2]), .place_done(done[2]),
      .place_fail(fail[2]), .food_valid(fv[2]), .x_food(xf[2]), .y_food(yf[2]),
      .occ_query_valid(qv[2]), .occ_query_x(qx[2]), .occ_query_y(qy[2]),
      .occ_resp_valid(rv[2]), .occ_hit(hit[2]));

   food_placer u_dut3 (
      .clk(clk), .rst_n(rst_n), .place_req(req[3]), .busy(busy[3]), .place_done(done[3]),
      .place_fail(fail[3]), .food_valid(fv[3]), .x_food(xf[3]), .y_food(yf[3]),
      .occ_query_valid(qv[3]), .occ_query_x(qx[3]), .occ_query_y(qy[3]),
      .occ_resp_valid(rv3), .occ_hit(1'b0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] lstep(input logic [19:0] v);
      return {v[18:0], v[19] ^ v[16]};
   endfunction

   function automatic logic [9:0] cand_x(input logic [19:0] v);
      return {v[9:3], 3'b000};
   endfunction

   function automatic logic [9:0] cand_y(input logic [19:0] v);
      return {v[19:13], 3'b000};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr <= 20'h00001;
         m_prev <= 20'h00001;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= lstep(m_lfsr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed still running, required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [19:0] v;
      logic        found;
      int          dones;
      logic        pd;
      logic        pi;

      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      for (int d = 0; d < 4; d++) req[d] = 1'b0;
      for (int d = 0; d < 3; d++) begin
         rv[d]  = 1'b0;
         hit[d] = 1'b0;
      end

      // Reset state of every instance
      repeat (3) tick();
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("rst_busy%0d", d), busy[d], 0);
         chk($sformatf("rst_done%0d", d), done[d], 0);
         chk($sformatf("rst_fail%0d", d), fail[d], 0);
         chk($sformatf("rst_fv%0d", d), fv[d], 0);
         chk($sformatf("rst_x%0d", d), xf[d], 0);
         chk($sformatf("rst_y%0d", d), yf[d], 0);
         chk($sformatf("rst_qv%0d", d), qv[d], 0);
         chk($sformatf("rst_qx%0d", d), qx[d], 0);
         chk($sformatf("rst_qy%0d", d), qy[d], 0);
      end
      rst_n = 1'b1;

      // First request straight after reset: DRAW uses lfsr 0x00002 -> (0,0)
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      chk("lat_busy", busy[0], 1);
      chk("lat_done_early", done[0], 0);
      tick();
      chk("lat_done", done[0], 1);
      chk("lat_fail", fail[0], 0);
      chk("lat_busy_in_done", busy[0], 0);
      chk("seed_fv", fv[0], 1);
      chk("seed_x", xf[0], 0);
      chk("seed_y", yf[0], 0);

      // Request accepted at edge 13: DRAW uses lfsr 0x02000 -> x=0, y=8
      repeat (10) tick();
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      tick();
      chk("hand_done", done[0], 1);
      chk("hand_x", xf[0], 10'd0);
      chk("hand_y", yf[0], 10'd8);

      // Later requests against the LFSR model once the state is dense
      for (int k = 0; k < 3; k++) begin
         repeat (20 + 7 * k) tick();
         req[0] = 1'b1;
         tick();
         req[0] = 1'b0;
         v = m_lfsr;
         tick();
         chk($sformatf("mdl_done%0d", k), done[0], 1);
         chk($sformatf("mdl_fail%0d", k), fail[0], 0);
         chk($sformatf("mdl_x%0d", k), xf[0], cand_x(v));
         chk($sformatf("mdl_y%0d", k), yf[0], cand_y(v));
         chk($sformatf("mdl_xalign%0d", k), xf[0][2:0], 0);
      end

      // Occupancy: three hits then a miss, response one cycle after the query
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0;
      chk("occ_busy", busy[1], 1);
      for (int q = 0; q < 4; q++) begin
         logic [9:0] ex;
         logic [9:0] ey;
         found = 1'b0;
         for (int w = 0; w < 8 && !found; w++) begin
            @(negedge clk);
            if (qv[1]) found = 1'b1;
         end
         chk($sformatf("occ_issue%0d", q), found, 1);
         ex = cand_x(m_prev);
         ey = cand_y(m_prev);
         chk($sformatf("occ_qx%0d", q), qx[1], ex);
         chk($sformatf("occ_qy%0d", q), qy[1], ey);
         tick();
         chk($sformatf("occ_hold_v%0d", q), qv[1], 1);
         chk($sformatf("occ_hold_x%0d", q), qx[1], ex);
         chk($sformatf("occ_hold_y%0d", q), qy[1], ey);
         rv[1]  = 1'b1;
         hit[1] = (q < 3);
         tick();
         rv[1]  = 1'b0;
         hit[1] = 1'b0;
         chk($sformatf("occ_qv_drop%0d", q), qv[1], 0);
         if (q < 3) begin
            chk($sformatf("occ_nodone%0d", q), done[1], 0);
            chk($sformatf("occ_busy%0d", q), busy[1], 1);
         end else begin
            chk("occ_done", done[1], 1);
            chk("occ_fail", fail[1], 0);
            chk("occ_commit_x", xf[1], ex);
            chk("occ_commit_y", yf[1], ey);
            chk("occ_fv", fv[1], 1);
         end
      end
      tick();
      chk("occ_extra_query", qv[1], 0);

      // Spurious responses while idle, then a response already present when the query rises
      rv[1]  = 1'b1;
      hit[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("spur_busy%0d", i), busy[1], 0);
         chk($sformatf("spur_done%0d", i), done[1], 0);
         chk($sformatf("spur_qv%0d", i), qv[1], 0);
      end
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0;
      chk("same_busy", busy[1], 1);
      tick();
      begin
         logic [9:0] ex;
         logic [9:0] ey;
         ex = cand_x(m_prev);
         ey = cand_y(m_prev);
         chk("same_qv", qv[1], 1);
         chk("same_qx", qx[1], ex);
         tick();
         chk("same_done", done[1], 1);
         chk("same_fail", fail[1], 0);
         chk("same_x", xf[1], ex);
         chk("same_y", yf[1], ey);
         chk("same_qv_drop", qv[1], 0);
      end
      rv[1] = 1'b0;
      tick();

      // Unreachable window, MAX_TRIES=5: fail after exactly five DRAW cycles
      req[2] = 1'b1;
      tick();
      req[2] = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i < 5) begin
            chk($sformatf("fail_wait_done%0d", i), done[2], 0);
            chk($sformatf("fail_wait_busy%0d", i), busy[2], 1);
         end else begin
            chk("fail_done", done[2], 1);
            chk("fail_fail", fail[2], 1);
            chk("fail_busy", busy[2], 0);
            chk("fail_fv", fv[2], 0);
            chk("fail_x", xf[2], 0);
            chk("fail_y", yf[2], 0);
         end
      end
      tick();
      chk("fail_pulse_done", done[2], 0);
      chk("fail_pulse_fail", fail[2], 0);

      // Request held high for 50 cycles against an always-miss zero-delay responder
      dones = 0;
      pd    = 1'b0;
      pi    = 1'b0;
      req[3] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("hold_overlap", busy[3] & done[3], 0);
         if (pd) begin
            chk("hold_idle_busy", busy[3], 0);
            chk("hold_idle_done", done[3], 0);
         end
         if (pi) chk("hold_rebusy", busy[3], 1);
         if (done[3] && !fail[3]) begin
            chk("hold_win", (xf[3] >= 10'd152) && (xf[3] <= 10'd776) &&
                            (yf[3] >= 10'd40) && (yf[3] <= 10'd504), 1);
            chk("hold_align", {xf[3][2:0], yf[3][2:0]}, 0);
         end
         pi = pd;
         pd = done[3];
         if (done[3]) dones++;
      end
      req[3] = 1'b0;
      chk("hold_dones", dones >= 2, 1);

      // Reset asserted while a query is outstanding
      tick();
      repeat (40) tick();
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0;
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
         @(negedge clk);
         if (qv[1]) found = 1'b1;
      end
      chk("arst_query_seen", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy[1], 0);
      chk("arst_done", done[1], 0);
      chk("arst_qv", qv[1], 0);
      chk("arst_qx", qx[1], 0);
      chk("arst_qy", qy[1], 0);
      chk("arst_fv", fv[1], 0);
      chk("arst_x", xf[1], 0);
      chk("arst_y", yf[1], 0);
      chk("arst_fv0", fv[0], 0);
      @(negedge clk);
      rst_n  = 1'b1;
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      chk("arst_nodone_a", done[1], 0);
      chk("arst_idle", busy[1], 0);
      tick();
      chk("arst_nodone_b", done[1], 0);
      chk("reseed_done", done[0], 1);
      chk("reseed_fv", fv[0], 1);
      chk("reseed_x", xf[0], 0);
      chk("reseed_y", yf[0], 0);
      repeat (25) tick();
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      v = m_lfsr;
      tick();
      chk("reseed_mdl_done", done[0], 1);
      chk("reseed_mdl_x", xf[0], cand_x(v));
      chk("reseed_mdl_y", yf[0], cand_y(v));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
